// File: rtl/arm_single_cycle_core_if.sv
// Bus between the core, the instruction source and the data RAM.
// Carries PC/Instruction for fetch and ALUResult/WriteData/ReadData/write_enable for data access.
// No flow control: every signal is valid within the cycle it is presented.
interface arm_single_cycle_core_if;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic        write_enable;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (
    output PC, write_enable, ALUResult, WriteData,
    input  Instruction, ReadData
  );

  modport slave (
    input  PC, write_enable, ALUResult, WriteData,
    output Instruction, ReadData
  );
endinterface

// File: rtl/arm_single_cycle_core.sv
// Single-cycle ARMv4-subset core: data processing, LDR/STR word, B/BL, all conditional.
// Latency: each instruction commits PC, registers, flags and RAM write on one rising edge.
// Backpressure: none; Instruction and ReadData must be valid within the same cycle.
module arm_single_cycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic clk,
  input logic reset,
  arm_single_cycle_core_if.master bus
);
  localparam logic [3:0] CMD_AND = 4'b0000, CMD_EOR = 4'b0001, CMD_SUB = 4'b0010,
                         CMD_RSB = 4'b0011, CMD_ADD = 4'b0100, CMD_ORR = 4'b1100,
                         CMD_MOV = 4'b1101, CMD_MVN = 4'b1111, CMD_CMP = 4'b1010;

  logic [31:0] pc_q;
  logic [31:0] rf [0:14];
  logic [3:0]  nzcv;  // {N, Z, C, V}

  logic [1:0]  op;
  logic [3:0]  cmd, rn, rd, rm;
  assign op  = bus.Instruction[27:26];
  assign cmd = bus.Instruction[24:21];
  assign rn  = bus.Instruction[19:16];
  assign rd  = bus.Instruction[15:12];
  assign rm  = bus.Instruction[3:0];

  logic [31:0] pc_plus4, pc_plus8, rn_val, rd_val, rm_val;
  assign pc_plus4 = pc_q + 32'd4;
  assign pc_plus8 = pc_q + 32'd8;
  // R15 reads as the address of the current instruction plus 8
  assign rn_val = (rn == 4'd15) ? pc_plus8 : rf[rn];
  assign rd_val = (rd == 4'd15) ? pc_plus8 : rf[rd];
  assign rm_val = (rm == 4'd15) ? pc_plus8 : rf[rm];

  // Condition evaluation against the current flags; 1111 behaves like AL
  logic cond_ok;
  always_comb begin
    cond_ok = 1'b1;
    case (bus.Instruction[31:28])
      4'b0000: cond_ok = nzcv[2];
      4'b0001: cond_ok = !nzcv[2];
      4'b0010: cond_ok = nzcv[1];
      4'b0011: cond_ok = !nzcv[1];
      4'b0100: cond_ok = nzcv[3];
      4'b0101: cond_ok = !nzcv[3];
      4'b0110: cond_ok = nzcv[0];
      4'b0111: cond_ok = !nzcv[0];
      4'b1000: cond_ok = nzcv[1] && !nzcv[2];
      4'b1001: cond_ok = !nzcv[1] || nzcv[2];
      4'b1010: cond_ok = (nzcv[3] == nzcv[0]);
      4'b1011: cond_ok = (nzcv[3] != nzcv[0]);
      4'b1100: cond_ok = !nzcv[2] && (nzcv[3] == nzcv[0]);
      4'b1101: cond_ok = nzcv[2] || (nzcv[3] != nzcv[0]);
      default: cond_ok = 1'b1;
    endcase
  end

  // Operand2 and ALU; subtraction is done as x + ~y + 1 so carry-out means "no borrow"
  logic [63:0] imm_rot;
  logic [31:0] op2, alu_x, alu_y, dp_res;
  logic [32:0] alu_sum;
  logic        alu_cin, dp_valid, dp_arith, alu_v;
  always_comb begin
    imm_rot  = {24'd0, bus.Instruction[7:0], 24'd0, bus.Instruction[7:0]} >> {bus.Instruction[11:8], 1'b0};
    op2      = bus.Instruction[25] ? imm_rot[31:0] : rm_val;
    alu_x    = rn_val;
    alu_y    = op2;
    alu_cin  = 1'b0;
    dp_valid = 1'b1;
    dp_arith = 1'b0;
    case (cmd)
      CMD_SUB, CMD_CMP: begin alu_y = ~op2; alu_cin = 1'b1; dp_arith = 1'b1; end
      CMD_RSB: begin alu_x = op2; alu_y = ~rn_val; alu_cin = 1'b1; dp_arith = 1'b1; end
      CMD_ADD: dp_arith = 1'b1;
      default: ;
    endcase
    alu_sum = {1'b0, alu_x} + {1'b0, alu_y} + {32'd0, alu_cin};
    alu_v   = (alu_x[31] == alu_y[31]) && (alu_sum[31] != alu_x[31]);
    case (cmd)
      CMD_AND: dp_res = rn_val & op2;
      CMD_EOR: dp_res = rn_val ^ op2;
      CMD_ORR: dp_res = rn_val | op2;
      CMD_MOV: dp_res = op2;
      CMD_MVN: dp_res = ~op2;
      CMD_SUB, CMD_RSB, CMD_ADD, CMD_CMP: dp_res = alu_sum[31:0];
      default: begin dp_res = alu_sum[31:0]; dp_valid = 1'b0; end
    endcase
  end

  // Memory address is always pre-indexed with no writeback
  logic [31:0] mem_off, mem_addr, br_target;
  assign mem_off   = bus.Instruction[25] ? rm_val : {20'd0, bus.Instruction[11:0]};
  assign mem_addr  = bus.Instruction[23] ? (rn_val + mem_off) : (rn_val - mem_off);
  assign br_target = pc_plus8 + {{6{bus.Instruction[23]}}, bus.Instruction[23:0], 2'b00};

  // Next-state selection: register write, flags and PC for the current instruction
  logic        reg_we, flags_we;
  logic [3:0]  reg_addr, flags_next;
  logic [31:0] reg_data, pc_next;
  always_comb begin
    reg_we     = 1'b0;
    reg_addr   = rd;
    reg_data   = dp_res;
    flags_we   = 1'b0;
    flags_next = nzcv;
    pc_next    = pc_plus4;
    if (cond_ok) begin
      case (op)
        2'b00: if (dp_valid) begin
          reg_we   = (cmd != CMD_CMP);
          flags_we = (cmd == CMD_CMP) || bus.Instruction[20];
          flags_next = dp_arith ? {dp_res[31], dp_res == 32'd0, alu_sum[32], alu_v}
                                : {dp_res[31], dp_res == 32'd0, nzcv[1:0]};
        end
        2'b01: if (bus.Instruction[20]) begin
          reg_we   = 1'b1;
          reg_data = bus.ReadData;
        end
        2'b10: begin
          pc_next = br_target;
          if (bus.Instruction[24]) begin
            reg_we   = 1'b1;
            reg_addr = 4'd14;
            reg_data = pc_plus4;
          end
        end
        default: ;
      endcase
    end
    if (reg_we && reg_addr == 4'd15) pc_next = reg_data;
  end

  // State commit on the rising edge; asynchronous clear while reset is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
      nzcv <= 4'b0000;
      for (int i = 0; i < 15; i++) rf[i] <= 32'd0;
    end else begin
      pc_q <= pc_next;
      if (flags_we) nzcv <= flags_next;
      if (reg_we && reg_addr != 4'd15) rf[reg_addr] <= reg_data;
    end
  end

  assign bus.PC           = pc_q;
  assign bus.write_enable = reset && cond_ok && (op == 2'b01) && !bus.Instruction[20];
  assign bus.ALUResult    = (op == 2'b01) ? mem_addr : (op == 2'b10) ? br_target : dp_res;
  assign bus.WriteData    = rd_val;
endmodule

// File: tb/tb_arm_single_cycle_core.sv
// Testbench for arm_single_cycle_core: directed scenarios plus random instructions.
// A behavioural ISA model (registers, flags, PC, RAM) predicts every visible output.
// The bench owns the data RAM (asynchronous read, write on rising edge).
module tb_arm_single_cycle_core;
  localparam logic [31:0] NOP = 32'hEC00_0000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  arm_single_cycle_core_if bus ();
  arm_single_cycle_core #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Bench-side data RAM seen by the DUT
  logic [31:0] tb_ram [0:63];
  assign bus.ReadData = tb_ram[bus.ALUResult[7:2]];
  always @(posedge clk) if (bus.write_enable) tb_ram[bus.ALUResult[7:2]] <= bus.WriteData;

  // Reference model state
  logic [31:0] m_reg [0:14];
  logic [31:0] m_mem [0:63];
  logic [31:0] m_pc;
  logic [3:0]  m_nzcv;

  task automatic model_reset();
    m_pc = 32'd0;
    m_nzcv = 4'd0;
    for (int i = 0; i < 15; i++) m_reg[i] = 32'd0;
  endtask

  function automatic logic [31:0] rd_model(input logic [3:0] r, input logic [31:0] pc8);
    return (r == 4'd15) ? pc8 : m_reg[r];
  endfunction

  function automatic bit cond_holds(input logic [3:0] c);
    bit n, z, cy, v;
    {n, z, cy, v} = m_nzcv;
    case (c)
      4'd0: return z;        4'd1: return !z;
      4'd2: return cy;       4'd3: return !cy;
      4'd4: return n;        4'd5: return !n;
      4'd6: return v;        4'd7: return !v;
      4'd8: return cy && !z; 4'd9: return !cy || z;
      4'd10: return n == v;  4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  // Executes one instruction on the model; returns the expected bus outputs
  task automatic model_step(input logic [31:0] ins, output logic ewe, output logic [31:0] eaddr,
                            output logic [31:0] ewd, output logic [31:0] ealu, output logic chk_alu);
    logic [31:0] pc8, a, b, res, off, addr, nxt;
    logic wr, arith, cy, v;
    int ia, ib, imm;
    longint unsigned ua;
    longint sa;
    pc8 = m_pc + 32'd8;
    a = rd_model(ins[19:16], pc8);
    ewe = 1'b0; eaddr = 32'd0; ewd = 32'd0; ealu = 32'd0; chk_alu = 1'b0;
    nxt = m_pc + 32'd4;
    if (cond_holds(ins[31:28])) begin
      case (ins[27:26])
        2'b00: begin
          if (ins[25]) begin
            b = {24'd0, ins[7:0]};
            for (int k = 0; k < 2 * int'(ins[11:8]); k++) b = {b[0], b[31:1]};
          end else b = rd_model(ins[3:0], pc8);
          ia = a; ib = b; wr = 1'b1; arith = 1'b0; cy = 1'b0; v = 1'b0; res = 32'd0;
          chk_alu = 1'b1;
          case (ins[24:21])
            4'b0000: res = a & b;
            4'b0001: res = a ^ b;
            4'b1100: res = a | b;
            4'b1101: res = b;
            4'b1111: res = ~b;
            4'b0100: begin
              ua = longint'(a) + longint'(b); res = a + b; cy = ua > 64'hFFFF_FFFF;
              sa = longint'(ia) + longint'(ib); arith = 1'b1;
            end
            4'b0010, 4'b1010: begin
              res = a - b; cy = a >= b; sa = longint'(ia) - longint'(ib); arith = 1'b1;
              if (ins[24:21] == 4'b1010) wr = 1'b0;
            end
            4'b0011: begin
              res = b - a; cy = b >= a; sa = longint'(ib) - longint'(ia); arith = 1'b1;
            end
            default: begin wr = 1'b0; chk_alu = 1'b0; end
          endcase
          if (arith) v = (sa > 64'sd2147483647) || (sa < -64'sd2147483648);
          ealu = res;
          if (chk_alu && (ins[20] || ins[24:21] == 4'b1010)) begin
            m_nzcv[3] = res[31];
            m_nzcv[2] = (res == 32'd0);
            if (arith) begin m_nzcv[1] = cy; m_nzcv[0] = v; end
          end
          if (wr) begin
            if (ins[15:12] == 4'd15) nxt = res; else m_reg[ins[15:12]] = res;
          end
        end
        2'b01: begin
          off = ins[25] ? rd_model(ins[3:0], pc8) : {20'd0, ins[11:0]};
          addr = ins[23] ? a + off : a - off;
          ealu = addr; chk_alu = 1'b1;
          if (ins[20]) begin
            if (ins[15:12] == 4'd15) nxt = m_mem[addr[7:2]];
            else m_reg[ins[15:12]] = m_mem[addr[7:2]];
          end else begin
            ewe = 1'b1; eaddr = addr; ewd = rd_model(ins[15:12], pc8);
            m_mem[addr[7:2]] = ewd;
          end
        end
        2'b10: begin
          imm = int'(ins[23:0]);
          if (ins[23]) imm = imm - 32'sh0100_0000;
          nxt = pc8 + 32'(imm * 4);
          if (ins[24]) m_reg[14] = m_pc + 32'd4;
        end
        default: ;
      endcase
    end
    m_pc = nxt;
  endtask

  // Presents one instruction at a falling edge, compares against the model, advances one cycle
  task automatic exec(input logic [31:0] ins);
    logic ewe, chk_alu;
    logic [31:0] eaddr, ewd, ealu;
    bus.Instruction = ins;
    #1;
    checks++;
    if (bus.PC !== m_pc) begin errors++; $display("FAIL pc ins=%h got=%h exp=%h", ins, bus.PC, m_pc); end
    model_step(ins, ewe, eaddr, ewd, ealu, chk_alu);
    checks++;
    if (bus.write_enable !== ewe) begin errors++; $display("FAIL we ins=%h got=%b exp=%b", ins, bus.write_enable, ewe); end
    if (ewe) begin
      checks++;
      if (bus.WriteData !== ewd) begin errors++; $display("FAIL wdata ins=%h got=%h exp=%h", ins, bus.WriteData, ewd); end
    end
    if (chk_alu) begin
      checks++;
      if (bus.ALUResult !== ealu) begin errors++; $display("FAIL alu ins=%h got=%h exp=%h", ins, bus.ALUResult, ealu); end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    model_reset();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] cnd [6] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6};
    logic       exp [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    bus.Instruction = 32'hE580_1000;  // STR R1,[R0]
    reset = 1'b0;
    #1;
    checks++; if (bus.PC !== 32'd0) begin errors++; $display("FAIL reset_pc got=%h exp=0", bus.PC); end
    checks++; if (bus.write_enable !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", bus.write_enable); end
    checks++; if (bus.WriteData !== 32'd0) begin errors++; $display("FAIL reset_r1 got=%h exp=0", bus.WriteData); end
    @(negedge clk); @(negedge clk);
    #1;
    checks++; if (bus.PC !== 32'd0) begin errors++; $display("FAIL reset_hold_pc got=%h exp=0", bus.PC); end
    model_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.Instruction = NOP;
      #1;
      checks++;
      if (bus.PC !== 32'(i * 4)) begin errors++; $display("FAIL pc_seq got=%h exp=%h", bus.PC, i * 4); end
      exec(NOP);
    end
    // flags read as 0000 after reset
    for (int i = 0; i < 6; i++) begin
      bus.Instruction = {cnd[i], 28'h580_1000};
      #1;
      checks++;
      if (bus.write_enable !== exp[i]) begin errors++; $display("FAIL reset_flags cond=%h got=%b exp=%b", cnd[i], bus.write_enable, exp[i]); end
      exec({cnd[i], 28'h580_1000});
    end
  endtask

  task automatic test_mov_add_mem();
    exec(32'hE3A0_3005);  // MOV R3,#5
    exec(32'hE283_1001);  // ADD R1,R3,#1
    bus.Instruction = 32'h0583_1004;  // STREQ with Z=0: flags must be untouched
    #1;
    checks++; if (bus.write_enable !== 1'b0) begin errors++; $display("FAIL add_flags got=%b exp=0", bus.write_enable); end
    exec(32'h0583_1004);
    bus.Instruction = 32'hE583_1004;  // STR R1,[R3,#4]
    #1;
    checks++; if (bus.write_enable !== 1'b1) begin errors++; $display("FAIL str_we got=%b exp=1", bus.write_enable); end
    checks++; if (bus.ALUResult !== 32'd9) begin errors++; $display("FAIL str_addr got=%h exp=9", bus.ALUResult); end
    checks++; if (bus.WriteData !== 32'd6) begin errors++; $display("FAIL str_data got=%h exp=6", bus.WriteData); end
    exec(32'hE583_1004);
    exec(32'hE593_5004);  // LDR R5,[R3,#4]
    bus.Instruction = 32'hE583_5000;
    #1;
    checks++; if (bus.WriteData !== 32'd6) begin errors++; $display("FAIL ldr_r5 got=%h exp=6", bus.WriteData); end
    exec(32'hE583_5000);
  endtask

  task automatic test_subs_cond();
    logic [3:0] cnd [3] = '{4'h0, 4'h2, 4'h4};
    logic       exp [3] = '{1'b1, 1'b1, 1'b0};
    exec(32'hE053_2003);  // SUBS R2,R3,R3
    for (int i = 0; i < 3; i++) begin
      bus.Instruction = {cnd[i], 28'h583_1004};
      #1;
      checks++;
      if (bus.write_enable !== exp[i]) begin errors++; $display("FAIL subs_flags cond=%h got=%b exp=%b", cnd[i], bus.write_enable, exp[i]); end
      exec({cnd[i], 28'h583_1004});
    end
    exec(32'h0283_4001);  // ADDEQ R4,R3,#1
    exec(32'h1283_6001);  // ADDNE R6,R3,#1
    bus.Instruction = 32'hE583_2000;
    #1;
    checks++; if (bus.WriteData !== 32'd0) begin errors++; $display("FAIL subs_r2 got=%h exp=0", bus.WriteData); end
    exec(32'hE583_2000);
    bus.Instruction = 32'hE583_4000;
    #1;
    checks++; if (bus.WriteData !== 32'd6) begin errors++; $display("FAIL addeq_r4 got=%h exp=6", bus.WriteData); end
    exec(32'hE583_4000);
    bus.Instruction = 32'hE583_6000;
    #1;
    checks++; if (bus.WriteData !== 32'd0) begin errors++; $display("FAIL addne_r6 got=%h exp=0", bus.WriteData); end
    exec(32'hE583_6000);
  endtask

  task automatic test_cond_str();
    exec(32'hE353_0000);  // CMP R3,#0 -> Z=0
    bus.Instruction = 32'h0680_3001;
    #1;
    checks++; if (bus.write_enable !== 1'b0) begin errors++; $display("FAIL streq_skip got=%b exp=0", bus.write_enable); end
    exec(32'h0680_3001);
    exec(32'hE353_0005);  // CMP R3,#5 -> Z=1
    bus.Instruction = 32'h0680_3001;  // STREQ R3,[R0,R1]
    #1;
    checks++; if (bus.write_enable !== 1'b1) begin errors++; $display("FAIL streq_do got=%b exp=1", bus.write_enable); end
    checks++; if (bus.ALUResult !== 32'd6) begin errors++; $display("FAIL streq_addr got=%h exp=6", bus.ALUResult); end
    checks++; if (bus.WriteData !== 32'd5) begin errors++; $display("FAIL streq_data got=%h exp=5", bus.WriteData); end
    exec(32'h0680_3001);
  endtask

  task automatic test_random();
    logic [3:0] cmds [9] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hC, 4'hD, 4'hF, 4'hA};
    logic [31:0] ins;
    logic [3:0] cnd, rdi;
    for (int n = 0; n < 400; n++) begin
      cnd = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom_range(0, 15));
      rdi = ($urandom_range(0, 24) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5:
          ins = {cnd, 2'b00, 1'($urandom), cmds[$urandom_range(0, 8)], 1'($urandom),
                 4'($urandom_range(0, 15)), rdi, 12'($urandom)};
        6, 7, 8:
          ins = {cnd, 2'b01, 1'($urandom), 1'b1, 1'($urandom), 2'b00, 1'($urandom),
                 4'($urandom_range(0, 15)), rdi, 12'($urandom_range(0, 255))};
        default:
          ins = ($urandom_range(0, 3) == 0) ? {cnd, 28'h000_0000} | NOP
              : {cnd, 3'b101, 1'($urandom), 24'($urandom_range(0, 15)) - 24'd8};
      endcase
      exec(ins);
    end
  endtask

  task automatic test_branch();
    int guard;
    do_reset();
    exec(32'hEB00_0001);  // BL +1 at PC 0
    bus.Instruction = 32'hE583_E000;
    #1;
    checks++; if (bus.PC !== 32'h0000_000C) begin errors++; $display("FAIL bl_pc got=%h exp=c", bus.PC); end
    checks++; if (bus.WriteData !== 32'd4) begin errors++; $display("FAIL bl_lr got=%h exp=4", bus.WriteData); end
    exec(32'hE583_E000);
    guard = 0;
    while (m_pc != 32'h20 && guard < 20) begin exec(NOP); guard++; end
    exec(32'hEAFF_FFFE);  // B to self
    bus.Instruction = NOP;
    #1;
    checks++; if (bus.PC !== 32'h0000_0020) begin errors++; $display("FAIL b_self got=%h exp=20", bus.PC); end
    exec(NOP);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin tb_ram[i] = 32'd0; m_mem[i] = 32'd0; end
    bus.Instruction = NOP;
    model_reset();
    test_reset();
    test_mov_add_mem();
    test_subs_cond();
    test_cond_str();
    test_random();
    test_reset();
    test_branch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
